// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared state encoding and bit-timing constants for the UART RX.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

    // 48 MHz HFOSC / 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 417;
    localparam int CLKS_PER_BIT_SIM     = 16;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for asynchronous level inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx_stream.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_stream
// Description : 8N1 UART receiver delivering bytes over a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_stream
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int               c_cnt_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(HALF_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_rx_stream: CLKS_PER_BIT must be at least 4");
    end

    logic               rx_s;
    rx_state_e          state_q,  state_d;
    logic [c_cnt_w-1:0] clkcnt_q, clkcnt_d;
    logic [2:0]         bitcnt_q, bitcnt_d;
    logic [7:0]         shift_q,  shift_d;
    logic [7:0]         data_q,   data_d;
    logic               valid_q,  valid_d;
    logic               ferr_q,   ferr_d;
    logic               ovr_q,    ovr_d;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_rx),
        .o_sync  (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            clkcnt_q <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            clkcnt_q <= clkcnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        clkcnt_d = clkcnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d  = START;
                    clkcnt_d = '0;
                end
            end

            START: begin
                if (clkcnt_q == c_half_last) begin
                    clkcnt_d = '0;
                    bitcnt_d = '0;
                    state_d  = rx_s ? IDLE : DATA;
                end else begin
                    clkcnt_d = clkcnt_q + 1'b1;
                end
            end

            DATA: begin
                if (clkcnt_q == c_bit_last) begin
                    clkcnt_d = '0;
                    shift_d  = {rx_s, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    clkcnt_d = clkcnt_q + 1'b1;
                end
            end

            STOP: begin
                if (clkcnt_q == c_bit_last) begin
                    clkcnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                        // Holding register is free if empty or drained this cycle.
                        if (!valid_q || i_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        state_d = WAIT_HIGH;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    clkcnt_d = clkcnt_q + 1'b1;
                end
            end

            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d  = IDLE;
                clkcnt_d = '0;
                bitcnt_d = '0;
            end
        endcase
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
    assign o_busy      = (state_q != IDLE);

endmodule : uart_rx_stream
`default_nettype wire

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
- 8N1 UART receiver that turns the board's serial input into a byte stream with a valid/ready handshake.
- Feeds test data into the deflate bench on the iCE40 board, clocked from the 48 MHz HFOSC.
- It is the input-direction counterpart to the existing LED status outputs, so a host can push bytes in instead of only reading LED results.

Parameters:
- CLKS_PER_BIT, 417, clk cycles per UART bit (48 MHz / 115200 baud); minimum 4.
- HALF_BIT, CLKS_PER_BIT/2, sample offset from the start-bit falling edge.

Ports:
- clk  in  1  system clock (HFOSC)
- rst  in  1  asynchronous, active-high reset
- i_rx  in  1  raw serial line; idles high; asynchronous to clk
- o_data  out  8  received byte; valid while o_valid=1
- o_valid  out  1  byte available
- i_ready  in  1  consumer accepts byte when o_valid&&i_ready
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_overrun  out  1  one-cycle pulse: completed byte dropped, holding register full
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync-deasserted by the user of rst):
  - o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
  - Both synchroniser flops=1, state=IDLE, bit counter=0, clock counter=0.
- Synchroniser: 2 flops on i_rx; rx_s is the second flop. All logic uses rx_s only, adding 2 cycles of latency.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 -> START, clkcnt=0.
  - START: clkcnt counts up. At clkcnt==HALF_BIT-1, sample rx_s:
    - 0 -> DATA, clkcnt=0, bitcnt=0.
    - 1 -> IDLE (glitch rejected; no flag raised).
  - DATA: at clkcnt==CLKS_PER_BIT-1, shift rx_s into shift[7] (LSB first, right shift) and clear clkcnt.
    - bitcnt 0..7; after the bitcnt==7 sample -> STOP.
  - STOP: at clkcnt==CLKS_PER_BIT-1, sample rx_s:
    - 1 -> deliver (see below), then IDLE.
    - 0 -> o_frame_err pulse next cycle, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then IDLE. This keeps a break condition from retriggering starts.
- Delivery, evaluated in the cycle the stop bit is sampled high:
  - If o_valid==0, or o_valid&&i_ready in that same cycle: o_data<=shift, o_valid<=1 next cycle.
  - Otherwise: keep the old o_data/o_valid and pulse o_overrun next cycle. The new byte is lost.
- Handshake:
  - o_valid falls the cycle after o_valid&&i_ready, unless a new byte loads simultaneously, in which case it stays 1 with new data.
  - o_data is stable while o_valid=1 and not accepted.
  - i_ready has no effect when o_valid=0.
- Latency: i_rx stop-bit mid-point to o_valid=1 is 2 (sync) + 1 cycles.
- Counters: clkcnt is clog2(CLKS_PER_BIT) bits wide and never wraps past CLKS_PER_BIT-1. bitcnt is 3 bits.
- Reset mid-frame: the frame is abandoned, no flags are raised, and reception resumes on the next falling edge after rst drops.
- o_frame_err and o_overrun never assert in the same cycle, because a frame error produces no delivery.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding constants (IDLE=0, START=1, DATA=2, STOP=3, WAIT_HIGH=4, 3 bits).
  - The default CLKS_PER_BIT=417.
  - The bench value CLKS_PER_BIT_SIM=16.
- One natural sub-module: sync_2ff (parameterised reset value, async active-high rst), also reusable for future button inputs.
- The FSM, counters, shift register and holding register stay in uart_rx_stream.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
1. Send 0xA5 with i_ready=1 held high -> o_valid high exactly 1 cycle, o_data=0xA5, o_frame_err=o_overrun=0, o_busy back to 0 after the stop bit.
2. Send 0x3C with i_ready=0 for 200 cycles, then pulse i_ready for 1 cycle -> o_valid stays 1 with o_data=0x3C throughout, then drops the next cycle.
3. Send 0x11 then 0x22 back-to-back with i_ready=0 -> o_data stays 0x11, o_overrun pulses once at the 0x22 stop sample. After acceptance, no phantom second byte appears.
4. Send 0x7E with the stop bit driven low, then the line held low for 40 cycles, then high, then 0x81 -> one o_frame_err pulse, no o_valid for 0x7E, no start retrigger during the low period, then o_data=0x81 delivered.
5. Drive a 5-cycle low glitch on idle i_rx -> returns to IDLE with no o_valid and no flags. A following 0x00 byte is received correctly.
6. Assert rst during bit 4 of 0xF0, release it, then send 0x0F -> all outputs 0 during reset, and only 0x0F is delivered afterwards.
